// File: rtl/ram_port_arb_pkg.sv
// ram_port_arb_pkg: shared defaults for the RAM port arbiter.
// Holds geometry defaults, read latency and an index-width helper.
package ram_port_arb_pkg;

  localparam int unsigned AW_DEF     = 5;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned NREQ_DEF   = 2;
  localparam int unsigned RAM_RD_LAT = 1;

  // Width of a binary requester index; never zero.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a one-hot last-grant pointer.
// Ports: clk, rst (sync, active-high), req[N], advance -> gnt[N], idx.
module rr_arbiter
  import ram_port_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic                  advance,
  output logic [N-1:0]          gnt,
  output logic [idx_w(N)-1:0]   idx
);

  localparam int unsigned IW = idx_w(N);
  localparam int unsigned SW = IW + 1;

  logic [N-1:0]  r_last;
  logic [IW-1:0] w_last_idx;
  logic [SW-1:0] w_sum;
  logic [IW-1:0] w_pos;
  logic          w_hit;

  always_comb begin
    w_last_idx = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (r_last[k]) w_last_idx = IW'(k);
    end
  end

  // Walk N slots starting just after the last grant,
  // wrapping with a subtract instead of a modulo.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    w_hit = 1'b0;
    w_sum = '0;
    w_pos = '0;
    for (int s = 1; s <= int'(N); s++) begin
      w_sum = {1'b0, w_last_idx} + SW'(s);
      if (w_sum >= SW'(N)) w_sum = w_sum - SW'(N);
      w_pos = w_sum[IW-1:0];
      if (!w_hit && req[w_pos]) begin
        w_hit      = 1'b1;
        gnt[w_pos] = 1'b1;
        idx        = w_pos;
      end
    end
  end

  // Pointer parks on the last slot so slot 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= N'(1) << (N - 1);
    end else if (advance && w_hit) begin
      r_last <= gnt;
    end
  end

endmodule

// File: rtl/ram_port_arb.sv
// ram_port_arb: shares one dual-port RAM between NREQ requesters.
// Ports: req_* cmd in, req_ready/rsp_* out, ram_* RAM side pins.
module ram_port_arb
  import ram_port_arb_pkg::*;
#(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 ram_r_en,
  output logic [AW-1:0]        ram_r_addr,
  input  logic [DW-1:0]        ram_r_data,
  output logic                 ram_w_en,
  output logic [AW-1:0]        ram_w_addr,
  output logic [DW-1:0]        ram_w_data
);

  localparam int unsigned IW = idx_w(NREQ);

  logic [NREQ-1:0] w_wr_req;
  logic [NREQ-1:0] w_rd_req;
  logic [NREQ-1:0] w_wr_sel;
  logic [NREQ-1:0] w_rd_sel;
  logic [IW-1:0]   w_wr_idx;
  logic [IW-1:0]   w_rd_idx;
  logic [AW-1:0]   w_wr_addr;
  logic [DW-1:0]   w_wr_data;
  logic [AW-1:0]   w_rd_addr;
  logic            w_wr_go;
  logic            w_rd_any;
  logic            w_hazard;
  logic            w_rd_go;

  logic            r_rsp_vld;
  logic [IW-1:0]   r_rsp_idx;

  assign w_wr_req = req_valid & req_we;
  assign w_rd_req = req_valid & ~req_we;

  rr_arbiter #(.N(NREQ)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_wr_req),
    .advance (w_wr_go),
    .gnt     (w_wr_sel),
    .idx     (w_wr_idx)
  );

  rr_arbiter #(.N(NREQ)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_rd_req),
    .advance (w_rd_go),
    .gnt     (w_rd_sel),
    .idx     (w_rd_idx)
  );

  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    w_rd_addr = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_wr_idx == IW'(i)) begin
        w_wr_addr = req_addr[i*AW +: AW];
        w_wr_data = req_wdata[i*DW +: DW];
      end
      if (w_rd_idx == IW'(i)) begin
        w_rd_addr = req_addr[i*AW +: AW];
      end
    end
  end

  assign w_wr_go  = !rst && (|w_wr_sel);
  assign w_rd_any = !rst && (|w_rd_sel);

  // Same-cycle read of the address being written is held back one
  // cycle so it observes the new data instead of racing the write.
  assign w_hazard = w_wr_go && w_rd_any &&
                    (w_rd_addr == w_wr_addr);
  assign w_rd_go  = w_rd_any && !w_hazard;

  always_comb begin
    req_ready = '0;
    if (w_wr_go) req_ready = req_ready | w_wr_sel;
    if (w_rd_go) req_ready = req_ready | w_rd_sel;
  end

  assign ram_w_en   = w_wr_go;
  assign ram_w_addr = w_wr_go ? w_wr_addr : '0;
  assign ram_w_data = w_wr_go ? w_wr_data : '0;
  assign ram_r_en   = w_rd_go;
  assign ram_r_addr = w_rd_go ? w_rd_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld <= 1'b0;
      r_rsp_idx <= '0;
    end else begin
      r_rsp_vld <= w_rd_go;
      r_rsp_idx <= w_rd_idx;
    end
  end

  // Gating with rst drops a read accepted just before reset.
  always_comb begin
    rsp_valid = '0;
    if (r_rsp_vld && !rst) rsp_valid[r_rsp_idx] = 1'b1;
  end

  assign rsp_rdata = (r_rsp_vld && !rst) ? ram_r_data : '0;

endmodule
